pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Consumes the hazard requests raised in ID (load-to-use stall, branch control stall, IF/ID flush, HLT decode) and drives the actual pipeline-register enables and flushes for the 5-stage core.
- Also sequences the halt drain, keeps saturating stall/flush statistics, and flags a stall watchdog timeout.
- Sits between the hazard detection logic and the pc_update / if_id / id_ex / ex_mem / mem_wb pipeline registers.

Parameters:
- CNT_W, 16, width of the statistics counters
- MAX_STALL, 8, consecutive stall cycles before the timeout flag sets (legal range 1..2^CNT_W-1)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- l2u_stall  in  1  load-to-use stall request
- control_stall  in  1  branch waits on flags or rs
- if_id_flush_req  in  1  taken branch; squash the instruction in IF
- hlt_id  in  1  HLT opcode currently in ID
- mem_wb_hlt  in  1  HLT has reached MEM/WB
- pc_wen  out  1  PC register write enable
- if_id_wen  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_flush  out  1  ID/EX loads a bubble (all control bits zero)
- ex_mem_wen  out  1  EX/MEM write enable
- mem_wb_wen  out  1  MEM/WB write enable
- halted  out  1  core halted
- stall_timeout  out  1  sticky watchdog flag
- stall_cnt  out  CNT_W  total stall cycles, saturating
- flush_cnt  out  CNT_W  total flushes, saturating
- state  out  2  current FSM state, for debug

Behaviour:
- Reset (asynchronous assertion, synchronous release):
  - FSM enters RUN.
  - stall_cnt = 0, flush_cnt = 0, consecutive-stall counter = 0, stall_timeout = 0, halted = 0.
  - Enable and flush outputs take their RUN/idle values: all wen = 1, all flush = 0.
- Timing: outputs are combinational from the registered state plus the current inputs, so the response takes effect in the same cycle (zero latency). Counters, flags and state update on the rising clk edge.
- FSM states: RUN = 0, DRAIN = 1, HALTED = 2. Encoding 3 is unused and recovers to RUN on the next edge.
- RUN priority, highest first:
  - l2u_stall or control_stall:
    - pc_wen = 0, if_id_wen = 0, id_ex_flush = 1, if_id_flush = 0.
    - ex_mem_wen = 1, mem_wb_wen = 1.
    - An if_id_flush_req arriving in the same cycle is ignored, because the branch has not resolved yet.
  - if_id_flush_req without a stall:
    - pc_wen = 1, if_id_wen = 1, if_id_flush = 1, id_ex_flush = 0.
    - flush_cnt increments.
  - hlt_id without a stall or flush:
    - Next state is DRAIN.
    - This cycle: pc_wen = 0, if_id_flush = 1. HLT still advances into ID/EX.
  - Otherwise all enables are 1 and all flushes are 0.
- DRAIN:
  - pc_wen = 0, if_id_wen = 1, if_id_flush = 1, id_ex_flush = 1.
  - ex_mem_wen = 1, mem_wb_wen = 1.
  - Stall, flush and hlt inputs are ignored.
  - When mem_wb_hlt = 1, the next state is HALTED.
- HALTED:
  - All wen = 0, all flush = 0, halted = 1.
  - The FSM leaves HALTED only on reset.
- Statistics:
  - stall_cnt increments on every RUN cycle with (l2u_stall | control_stall). It saturates at all-ones and does not wrap.
  - flush_cnt saturates the same way.
- Watchdog:
  - The consecutive-stall counter increments on each stalled RUN cycle, clears on any non-stalled cycle, and saturates.
  - stall_timeout sets on the edge where the counter reaches MAX_STALL. It is sticky until reset.
- Reset during DRAIN or HALTED returns the FSM to RUN immediately (asynchronously).
- mem_wb_hlt while in RUN is a protocol error and is ignored.

Decomposition:
- Shared package/header holds:
  - state encodings ST_RUN, ST_DRAIN, ST_HALTED
  - the HLT opcode constant 4'b1111, beside the existing opcode localparams
- One sub-module: sat_counter (parameterised width, inc, clear, saturating). Instantiate it three times: stall_cnt, flush_cnt, consecutive-stall.

Test Plan:
- Reset check: assert rst mid-cycle -> all wen = 1, flushes = 0, halted = 0, counters = 0, state = 0, with no clock edge needed.
- Load-to-use: l2u_stall = 1 for 1 cycle -> that cycle pc_wen = 0, if_id_wen = 0, id_ex_flush = 1. Next cycle all enables = 1. stall_cnt = 1.
- Branch priority: control_stall = 1 and if_id_flush_req = 1 together for 2 cycles, then if_id_flush_req = 1 alone -> if_id_flush = 0 during the stall cycles, then 1 on the third cycle. stall_cnt = 2, flush_cnt = 1.
- Watchdog: control_stall held for 8 cycles -> stall_timeout rises after the 8th edge and stays 1 after the stall drops. With MAX_STALL = 8, a 7-cycle stall leaves it at 0.
- Halt sequence: hlt_id pulse, then mem_wb_hlt three cycles later -> state goes 0 -> 1 -> 2, pc_wen stays 0 from the hlt_id cycle onward, and halted = 1 with every wen = 0. Subsequent l2u_stall pulses leave stall_cnt unchanged.
- Saturation and reset-in-drain: with CNT_W = 2, 5 stall cycles -> stall_cnt = 3. Assert rst while in DRAIN -> state returns to 0 and the counters clear.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encodings and core opcodes.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1111;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard requests in, pipeline-register enables/flushes and statistics out.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);

  logic             l2u_stall;
  logic             control_stall;
  logic             if_id_flush_req;
  logic             hlt_id;
  logic             mem_wb_hlt;
  logic             pc_wen;
  logic             if_id_wen;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_wen;
  logic             mem_wb_wen;
  logic             halted;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state;

  modport master (
    output l2u_stall, control_stall, if_id_flush_req, hlt_id, mem_wb_hlt,
    input  pc_wen, if_id_wen, if_id_flush, id_ex_flush, ex_mem_wen, mem_wb_wen,
    input  halted, stall_timeout, stall_cnt, flush_cnt, state
  );

  modport slave (
    input  l2u_stall, control_stall, if_id_flush_req, hlt_id, mem_wb_hlt,
    output pc_wen, if_id_wen, if_id_flush, id_ex_flush, ex_mem_wen, mem_wb_wen,
    output halted, stall_timeout, stall_cnt, flush_cnt, state
  );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Turns ID-stage hazard requests into pipeline register enables/flushes, sequences
// the HLT drain, and keeps saturating stall/flush statistics plus a stall watchdog.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_stall_controller_if.slave  bus
);

  state_e           state_q;
  state_e           state_d;
  logic             stall_req;
  logic             stall_run;
  logic             flush_run;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] consec_cnt;

  assign stall_req = bus.l2u_stall | bus.control_stall;
  assign stall_run = (state_q == ST_RUN) & stall_req;
  // A branch flush is only honoured once the stall that guards it has cleared.
  assign flush_run = (state_q == ST_RUN) & ~stall_req & bus.if_id_flush_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.pc_wen      = 1'b1;
    bus.if_id_wen   = 1'b1;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    bus.ex_mem_wen  = 1'b1;
    bus.mem_wb_wen  = 1'b1;
    bus.halted      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (stall_req) begin
          bus.pc_wen      = 1'b0;
          bus.if_id_wen   = 1'b0;
          bus.id_ex_flush = 1'b1;
        end else if (bus.if_id_flush_req) begin
          bus.if_id_flush = 1'b1;
        end else if (bus.hlt_id) begin
          // HLT moves on into ID/EX; fetch stops and IF is squashed behind it.
          bus.pc_wen      = 1'b0;
          bus.if_id_flush = 1'b1;
          state_d         = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        bus.pc_wen      = 1'b0;
        bus.if_id_flush = 1'b1;
        bus.id_ex_flush = 1'b1;
        if (bus.mem_wb_hlt) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        bus.pc_wen     = 1'b0;
        bus.if_id_wen  = 1'b0;
        bus.ex_mem_wen = 1'b0;
        bus.mem_wb_wen = 1'b0;
        bus.halted     = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_run),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_run),
    .clr (1'b0),
    .cnt (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_consec_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_run),
    .clr (~stall_run),
    .cnt (consec_cnt)
  );

  // Set on the edge where the consecutive count steps up to MAX_STALL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (stall_run && (consec_cnt >= CNT_W'(MAX_STALL - 1))) begin
      timeout_q <= 1'b1;
    end
  end

  assign bus.stall_timeout = timeout_q;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.flush_cnt     = flush_cnt;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench: main instance (CNT_W=16, MAX_STALL=8) and a narrow
// instance (CNT_W=2, MAX_STALL=3) for saturation and reset-in-drain.
module tb_pipeline_stall_controller;
  import pipeline_stall_controller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.CNT_W(16)) m_if ();
  pipeline_stall_controller_if #(.CNT_W(2))  s_if ();

  pipeline_stall_controller #(.CNT_W(16), .MAX_STALL(8)) dut_main (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  pipeline_stall_controller #(.CNT_W(2), .MAX_STALL(3)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  typedef struct packed {
    logic [5:0]  ctl;   // {pc_wen, if_id_wen, if_id_flush, id_ex_flush, ex_mem_wen, mem_wb_wen}
    logic        halted;
    logic        to;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [1:0]  st;
  } obs_t;

  typedef struct {
    bit   sel;
    int   id;
    obs_t exp;
  } item_t;

  localparam logic [5:0] C_IDLE  = 6'b110011;
  localparam logic [5:0] C_STALL = 6'b000111;
  localparam logic [5:0] C_FLUSH = 6'b111011;
  localparam logic [5:0] C_HLT   = 6'b011011;
  localparam logic [5:0] C_DRAIN = 6'b011111;
  localparam logic [5:0] C_HALT  = 6'b000000;

  item_t q[$];
  int    applied     = 0;
  int    miscompares = 0;
  int    vec_id      = 0;

  function automatic obs_t mk(logic [5:0] ctl, logic h, logic to, int sc, int fc, int st);
    obs_t o;
    o.ctl    = ctl;
    o.halted = h;
    o.to     = to;
    o.sc     = 16'(sc);
    o.fc     = 16'(fc);
    o.st     = 2'(st);
    return o;
  endfunction

  function automatic int min3(int v);
    return (v > 3) ? 3 : v;
  endfunction

  // in = {l2u_stall, control_stall, if_id_flush_req, hlt_id, mem_wb_hlt}
  task automatic vec(input bit sel, input logic r, input logic [4:0] in, input obs_t e);
    item_t it;
    logic [4:0] mi;
    logic [4:0] si;
    @(posedge clk);
    #1;
    mi = sel ? 5'b0 : in;
    si = sel ? in : 5'b0;
    rst = r;
    {m_if.l2u_stall, m_if.control_stall, m_if.if_id_flush_req, m_if.hlt_id, m_if.mem_wb_hlt} = mi;
    {s_if.l2u_stall, s_if.control_stall, s_if.if_id_flush_req, s_if.hlt_id, s_if.mem_wb_hlt} = si;
    it.sel = sel;
    it.id  = vec_id;
    it.exp = e;
    q.push_back(it);
    vec_id++;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      item_t it;
      obs_t  act;
      it = q.pop_front();
      if (it.sel) begin
        act = mk({s_if.pc_wen, s_if.if_id_wen, s_if.if_id_flush, s_if.id_ex_flush,
                  s_if.ex_mem_wen, s_if.mem_wb_wen}, s_if.halted, s_if.stall_timeout,
                 int'(s_if.stall_cnt), int'(s_if.flush_cnt), int'(s_if.state));
      end else begin
        act = mk({m_if.pc_wen, m_if.if_id_wen, m_if.if_id_flush, m_if.id_ex_flush,
                  m_if.ex_mem_wen, m_if.mem_wb_wen}, m_if.halted, m_if.stall_timeout,
                 int'(m_if.stall_cnt), int'(m_if.flush_cnt), int'(m_if.state));
      end
      applied++;
      if (act !== it.exp) begin
        miscompares++;
        $display("FAIL vec%0d dut%0d got ctl=%b h=%b to=%b sc=%0d fc=%0d st=%0d exp ctl=%b h=%b to=%b sc=%0d fc=%0d st=%0d",
                 it.id, it.sel, act.ctl, act.halted, act.to, act.sc, act.fc, act.st,
                 it.exp.ctl, it.exp.halted, it.exp.to, it.exp.sc, it.exp.fc, it.exp.st);
      end
    end
  end

  initial begin
    {m_if.l2u_stall, m_if.control_stall, m_if.if_id_flush_req, m_if.hlt_id, m_if.mem_wb_hlt} = 5'b0;
    {s_if.l2u_stall, s_if.control_stall, s_if.if_id_flush_req, s_if.hlt_id, s_if.mem_wb_hlt} = 5'b0;

    vec(0, 1'b1, 5'b00000, mk(C_IDLE, 0, 0, 0, 0, 0));
    vec(1, 1'b1, 5'b00000, mk(C_IDLE, 0, 0, 0, 0, 0));
    vec(0, 1'b0, 5'b00000, mk(C_IDLE, 0, 0, 0, 0, 0));

    // load-to-use, then branch stall with a flush request that must wait
    vec(0, 1'b0, 5'b10000, mk(C_STALL, 0, 0, 0, 0, 0));
    vec(0, 1'b0, 5'b00000, mk(C_IDLE,  0, 0, 1, 0, 0));
    vec(0, 1'b0, 5'b01100, mk(C_STALL, 0, 0, 1, 0, 0));
    vec(0, 1'b0, 5'b01100, mk(C_STALL, 0, 0, 2, 0, 0));
    vec(0, 1'b0, 5'b00100, mk(C_FLUSH, 0, 0, 3, 0, 0));
    vec(0, 1'b0, 5'b00000, mk(C_IDLE,  0, 0, 3, 1, 0));

    // 7-cycle stall stays below the watchdog, 8-cycle stall trips it
    for (int i = 0; i < 7; i++) vec(0, 1'b0, 5'b01000, mk(C_STALL, 0, 0, 3 + i, 1, 0));
    vec(0, 1'b0, 5'b00000, mk(C_IDLE, 0, 0, 10, 1, 0));
    for (int i = 0; i < 8; i++) vec(0, 1'b0, 5'b01000, mk(C_STALL, 0, 0, 10 + i, 1, 0));
    vec(0, 1'b0, 5'b00000, mk(C_IDLE, 0, 1, 18, 1, 0));
    vec(0, 1'b0, 5'b00000, mk(C_IDLE, 0, 1, 18, 1, 0));

    // halt: drain ignores hazards, then HALTED ignores further stalls
    vec(0, 1'b0, 5'b00010, mk(C_HLT,   0, 1, 18, 1, 0));
    vec(0, 1'b0, 5'b10110, mk(C_DRAIN, 0, 1, 18, 1, 1));
    vec(0, 1'b0, 5'b00000, mk(C_DRAIN, 0, 1, 18, 1, 1));
    vec(0, 1'b0, 5'b00001, mk(C_DRAIN, 0, 1, 18, 1, 1));
    vec(0, 1'b0, 5'b10000, mk(C_HALT,  1, 1, 18, 1, 2));
    vec(0, 1'b0, 5'b10000, mk(C_HALT,  1, 1, 18, 1, 2));
    vec(0, 1'b0, 5'b00000, mk(C_HALT,  1, 1, 18, 1, 2));

    // reset asserted mid-cycle while halted takes effect before any edge
    vec(0, 1'b1, 5'b00000, mk(C_IDLE, 0, 0, 0, 0, 0));
    vec(0, 1'b1, 5'b00000, mk(C_IDLE, 0, 0, 0, 0, 0));
    vec(0, 1'b0, 5'b00000, mk(C_IDLE, 0, 0, 0, 0, 0));

    // priority: stall beats HLT, flush beats HLT, mem_wb_hlt ignored in RUN
    vec(0, 1'b0, 5'b10010, mk(C_STALL, 0, 0, 0, 0, 0));
    vec(0, 1'b0, 5'b00001, mk(C_IDLE,  0, 0, 1, 0, 0));
    vec(0, 1'b0, 5'b00110, mk(C_FLUSH, 0, 0, 1, 0, 0));
    vec(0, 1'b0, 5'b00000, mk(C_IDLE,  0, 0, 1, 1, 0));

    // narrow instance: saturation at 3, watchdog at 3, reset during DRAIN
    for (int i = 0; i < 5; i++) vec(1, 1'b0, 5'b10000, mk(C_STALL, 0, (i >= 3), min3(i), 0, 0));
    vec(1, 1'b0, 5'b00000, mk(C_IDLE, 0, 1, 3, 0, 0));
    for (int i = 0; i < 4; i++) vec(1, 1'b0, 5'b00100, mk(C_FLUSH, 0, 1, 3, min3(i), 0));
    vec(1, 1'b0, 5'b00000, mk(C_IDLE,  0, 1, 3, 3, 0));
    vec(1, 1'b0, 5'b00010, mk(C_HLT,   0, 1, 3, 3, 0));
    vec(1, 1'b0, 5'b00000, mk(C_DRAIN, 0, 1, 3, 3, 1));
    vec(1, 1'b1, 5'b00000, mk(C_IDLE,  0, 0, 0, 0, 0));
    vec(1, 1'b0, 5'b00000, mk(C_IDLE,  0, 0, 0, 0, 0));

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
